// File: rtl/spi_slave_rx_param_if.sv
// SPI pin bundle and word handshake for the SPI slave receiver.
// The slave modport is the receiver's view; master is the driver/consumer side.
interface spi_slave_rx_param_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  spi_nss;
    logic                  spi_clock_in;
    logic                  spi_data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  overrun;
    logic                  frame_error;
    logic                  busy;

    modport slave (
        input  spi_nss, spi_clock_in, spi_data_in, data_ready,
        output data_out, data_valid, overrun, frame_error, busy
    );

    modport master (
        output spi_nss, spi_clock_in, spi_data_in, data_ready,
        input  data_out, data_valid, overrun, frame_error, busy
    );
endinterface

// File: rtl/spi_slave_rx_param.sv
// Oversampled SPI slave receiver: synchronised and glitch-filtered NSS/SCLK, any CPOL/CPHA,
// configurable width and bit order, valid/ready word output with overrun and framing-error pulses.
module spi_slave_rx_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FILTER_LEN = 2,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input logic                 clock,
    input logic                 reset,
    spi_slave_rx_param_if.slave bus
);
    localparam int                    CNT_W      = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [3:0]            FLT_LAST   = 4'(FILTER_LEN - 1);
    localparam logic                  IDLE_SCLK  = (CPOL != 0);
    localparam logic                  SAMPLE_LVL = (CPOL == CPHA);

    typedef enum logic {IDLE, SHIFT} StateT;

    logic [1:0]            nssSyncQ, sclkSyncQ, mosiSyncQ;
    logic                  nssFiltQ, sclkFiltQ, sclkDlyQ;
    logic [3:0]            nssCntQ, sclkCntQ;
    StateT                 stateQ;
    logic [CNT_W-1:0]      bitCntQ;
    logic [DATA_WIDTH-1:0] shiftQ, shiftD, dataQ;
    logic                  validQ, overrunQ, frameErrQ, busyQ;
    logic                  sampleEdge;

    // A filtered level only moves after the synchronised input disagrees for FILTER_LEN clocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nssSyncQ  <= 2'b11;
            sclkSyncQ <= {2{IDLE_SCLK}};
            mosiSyncQ <= 2'b00;
            nssFiltQ  <= 1'b1;
            sclkFiltQ <= IDLE_SCLK;
            sclkDlyQ  <= IDLE_SCLK;
            nssCntQ   <= '0;
            sclkCntQ  <= '0;
        end else begin
            nssSyncQ  <= {nssSyncQ[0], bus.spi_nss};
            sclkSyncQ <= {sclkSyncQ[0], bus.spi_clock_in};
            mosiSyncQ <= {mosiSyncQ[0], bus.spi_data_in};
            sclkDlyQ  <= sclkFiltQ;

            if (nssSyncQ[1] == nssFiltQ) begin
                nssCntQ <= '0;
            end else if (nssCntQ == FLT_LAST) begin
                nssFiltQ <= nssSyncQ[1];
                nssCntQ  <= '0;
            end else begin
                nssCntQ <= nssCntQ + 1'b1;
            end

            if (sclkSyncQ[1] == sclkFiltQ) begin
                sclkCntQ <= '0;
            end else if (sclkCntQ == FLT_LAST) begin
                sclkFiltQ <= sclkSyncQ[1];
                sclkCntQ  <= '0;
            end else begin
                sclkCntQ <= sclkCntQ + 1'b1;
            end
        end
    end

    assign sampleEdge = (sclkFiltQ != sclkDlyQ) && (sclkFiltQ == SAMPLE_LVL);

    always_comb begin
        shiftD = shiftQ;
        if (MSB_FIRST != 0) begin
            shiftD = {shiftQ[DATA_WIDTH-2:0], mosiSyncQ[1]};
        end else begin
            shiftD = {mosiSyncQ[1], shiftQ[DATA_WIDTH-1:1]};
        end
    end

    // NSS rising wins over a coincident sample edge; a completed word loads only into a free slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ    <= IDLE;
            bitCntQ   <= '0;
            shiftQ    <= '0;
            dataQ     <= '0;
            validQ    <= 1'b0;
            overrunQ  <= 1'b0;
            frameErrQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            overrunQ  <= 1'b0;
            frameErrQ <= 1'b0;
            if (validQ && bus.data_ready) begin
                validQ <= 1'b0;
            end
            case (stateQ)
                IDLE: begin
                    if (!nssFiltQ) begin
                        stateQ  <= SHIFT;
                        busyQ   <= 1'b1;
                        bitCntQ <= '0;
                        shiftQ  <= '0;
                    end
                end
                SHIFT: begin
                    if (nssFiltQ) begin
                        stateQ  <= IDLE;
                        busyQ   <= 1'b0;
                        bitCntQ <= '0;
                        if (bitCntQ != '0) begin
                            frameErrQ <= 1'b1;
                        end
                    end else if (sampleEdge) begin
                        shiftQ <= shiftD;
                        if (bitCntQ == LAST_BIT) begin
                            bitCntQ <= '0;
                            if (!validQ || bus.data_ready) begin
                                dataQ  <= shiftD;
                                validQ <= 1'b1;
                            end else begin
                                overrunQ <= 1'b1;
                            end
                        end else begin
                            bitCntQ <= bitCntQ + 1'b1;
                        end
                    end
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign bus.data_out    = dataQ;
    assign bus.data_valid  = validQ;
    assign bus.overrun     = overrunQ;
    assign bus.frame_error = frameErrQ;
    assign bus.busy        = busyQ;
endmodule

// File: tb/tb_spi_slave_rx_param.sv
// Directed bench for spi_slave_rx_param: four instances cover all CPOL/CPHA modes and LSB-first order.
// Expected words go into a queue as frames are driven and are matched against words the consumer accepts.
module tb_spi_slave_rx_param;
    localparam int DW = 16;
    localparam int FL = 2;
    localparam int H  = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          nss   [4];
    logic          sclk  [4];
    logic          mosi  [4];
    logic          ready [4];
    logic [DW-1:0] dout  [4];
    logic          valid [4];
    logic          ovr   [4];
    logic          ferr  [4];
    logic          busy  [4];

    // Instance g runs mode g (CPOL = g/2, CPHA = g%2); instance 3 is also LSB-first.
    for (genvar g = 0; g < 4; g++) begin : gen_dut
        spi_slave_rx_param_if #(.DATA_WIDTH(DW)) bus ();
        spi_slave_rx_param #(
            .DATA_WIDTH(DW),
            .FILTER_LEN(FL),
            .CPOL(g / 2),
            .CPHA(g % 2),
            .MSB_FIRST((g == 3) ? 0 : 1)
        ) dut (
            .clock(clock),
            .reset(reset),
            .bus(bus)
        );
        assign bus.spi_nss      = nss[g];
        assign bus.spi_clock_in = sclk[g];
        assign bus.spi_data_in  = mosi[g];
        assign bus.data_ready   = ready[g];
        assign dout[g]  = bus.data_out;
        assign valid[g] = bus.data_valid;
        assign ovr[g]   = bus.overrun;
        assign ferr[g]  = bus.frame_error;
        assign busy[g]  = bus.busy;
    end

    int nChecks = 0;
    int nFails  = 0;
    int cycleCnt = 0;
    int lastSample = 0;
    int ovrCnt [4] = '{default: 0};
    int ferrCnt[4] = '{default: 0};
    int riseCnt[4] = '{default: 0};
    int riseCycle[4] = '{default: 0};
    logic validDly[4] = '{default: 1'b0};
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] obsQ[$];

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Monitor: pulse counters and every word taken by the consumer.
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (ovr[i] === 1'b1) ovrCnt[i]++;
            if (ferr[i] === 1'b1) ferrCnt[i]++;
            if (valid[i] === 1'b1 && validDly[i] !== 1'b1) begin
                riseCnt[i]++;
                riseCycle[i] = cycleCnt;
            end
            if (valid[i] === 1'b1 && ready[i] === 1'b1) obsQ.push_back(dout[i]);
            validDly[i] = valid[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkScoreboard(input string tag);
        logic [DW-1:0] e;
        e = expQ.pop_front();
        checkOutput({tag, "_wordcount"}, 32'(obsQ.size()), 32'd1);
        if (obsQ.size() > 0) checkOutput({tag, "_data"}, 32'(obsQ.pop_front()), 32'(e));
        obsQ.delete();
    endtask

    task automatic frameStart(input int idx);
        nss[idx] = 1'b0;
        tick(H);
    endtask

    task automatic frameEnd(input int idx);
        tick(H);
        nss[idx] = 1'b1;
        tick(2 * H);
    endtask

    // Master side: drives nbits of word in the instance's mode and bit order, optionally with glitches.
    task automatic applyStimulus(input int idx, input logic [DW-1:0] word, input int nbits, input bit glitch);
        logic cpol, cpha, bitv;
        bit   msb;
        int   pos;
        cpol = logic'(idx / 2);
        cpha = logic'(idx % 2);
        msb  = (idx != 3);
        for (int b = 0; b < nbits; b++) begin
            pos  = msb ? (DW - 1 - b) : b;
            bitv = word[pos];
            if (cpha == 1'b0) begin
                mosi[idx] = bitv;
                if (glitch && b == 5) begin
                    tick(8); sclk[idx] = ~sclk[idx]; tick(1); sclk[idx] = ~sclk[idx]; tick(H - 9);
                end else if (glitch && b == 10) begin
                    tick(8); nss[idx] = 1'b1; tick(1); nss[idx] = 1'b0; tick(H - 9);
                end else begin
                    tick(H);
                end
                sclk[idx] = ~cpol;
                lastSample = cycleCnt;
                tick(H);
                sclk[idx] = cpol;
            end else begin
                sclk[idx] = ~cpol;
                mosi[idx] = bitv;
                tick(H);
                sclk[idx] = cpol;
                lastSample = cycleCnt;
                tick(H);
            end
        end
    endtask

    initial begin
        int r0, f0, o0, lat;
        logic [DW-1:0] modeWord;
        for (int i = 0; i < 4; i++) begin
            nss[i] = 1'b1; sclk[i] = logic'(i / 2); mosi[i] = 1'b0; ready[i] = 1'b1;
        end
        reset = 1'b1;
        tick(3);
        checkOutput("reset_data", 32'(dout[0]), 32'h0);
        checkOutput("reset_valid", 32'(valid[0]), 32'h0);
        checkOutput("reset_busy", 32'(busy[0]), 32'h0);
        checkOutput("reset_ovr_ferr", {30'd0, ovr[0], ferr[0]}, 32'h0);
        reset = 1'b0;
        tick(5);

        // Mode 0 word, latency from last sampling edge to data_valid.
        r0 = riseCnt[0]; f0 = ferrCnt[0]; o0 = ovrCnt[0];
        expQ.push_back(16'hA5C3);
        frameStart(0);
        checkOutput("busy_in_frame", 32'(busy[0]), 32'h1);
        applyStimulus(0, 16'hA5C3, DW, 1'b0);
        frameEnd(0);
        lat = riseCycle[0] - lastSample;
        checkOutput("m0_latency_ok", 32'((lat >= FL + 3) && (lat <= FL + 4)), 32'h1);
        checkOutput("m0_valid_pulses", 32'(riseCnt[0] - r0), 32'h1);
        checkOutput("m0_errors", 32'((ferrCnt[0] - f0) + (ovrCnt[0] - o0)), 32'h0);
        checkOutput("busy_after_frame", 32'(busy[0]), 32'h0);
        checkScoreboard("m0_A5C3");

        // Modes 1..3; instance 3 receives the word LSB-first.
        modeWord = 16'h1234;
        for (int m = 1; m < 4; m++) begin
            expQ.push_back(modeWord);
            frameStart(m);
            applyStimulus(m, modeWord, DW, 1'b0);
            frameEnd(m);
            checkScoreboard($sformatf("mode%0d_1234", m));
            checkOutput($sformatf("mode%0d_ferr", m), 32'(ferrCnt[m]), 32'h0);
        end

        // Sub-filter glitches on SCLK and NSS mid-word.
        f0 = ferrCnt[0];
        expQ.push_back(16'hBEEF);
        frameStart(0);
        applyStimulus(0, 16'hBEEF, DW, 1'b1);
        frameEnd(0);
        checkScoreboard("glitch_BEEF");
        checkOutput("glitch_ferr", 32'(ferrCnt[0] - f0), 32'h0);

        // Partial frame of 7 bits, then a clean 0x00FF frame.
        r0 = riseCnt[0]; f0 = ferrCnt[0];
        frameStart(0);
        applyStimulus(0, 16'hABCD, 7, 1'b0);
        frameEnd(0);
        checkOutput("partial_ferr", 32'(ferrCnt[0] - f0), 32'h1);
        checkOutput("partial_no_valid", 32'(riseCnt[0] - r0), 32'h0);
        checkOutput("partial_no_word", 32'(obsQ.size()), 32'h0);
        expQ.push_back(16'h00FF);
        frameStart(0);
        applyStimulus(0, 16'h00FF, DW, 1'b0);
        frameEnd(0);
        checkScoreboard("after_partial_00FF");

        // Consumer stalled across two words in one frame.
        ready[0] = 1'b0;
        o0 = ovrCnt[0];
        expQ.push_back(16'h1111);
        frameStart(0);
        applyStimulus(0, 16'h1111, DW, 1'b0);
        applyStimulus(0, 16'h2222, DW, 1'b0);
        frameEnd(0);
        checkOutput("stall_valid", 32'(valid[0]), 32'h1);
        checkOutput("stall_data", 32'(dout[0]), 32'h1111);
        checkOutput("stall_overrun", 32'(ovrCnt[0] - o0), 32'h1);
        ready[0] = 1'b1;
        tick(2);
        checkOutput("drain_valid", 32'(valid[0]), 32'h0);
        checkOutput("drain_data", 32'(dout[0]), 32'h1111);
        checkScoreboard("drain_1111");

        // Reset after 9 bits, then a fresh frame.
        f0 = ferrCnt[0];
        frameStart(0);
        applyStimulus(0, 16'hFFFF, 9, 1'b0);
        tick(3);
        reset = 1'b1;
        #1;
        checkOutput("midreset_data", 32'(dout[0]), 32'h0);
        checkOutput("midreset_valid_busy", {30'd0, valid[0], busy[0]}, 32'h0);
        nss[0] = 1'b1;
        sclk[0] = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(5);
        expQ.push_back(16'h8001);
        frameStart(0);
        applyStimulus(0, 16'h8001, DW, 1'b0);
        frameEnd(0);
        checkScoreboard("post_reset_8001");
        checkOutput("post_reset_ferr", 32'(ferrCnt[0] - f0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx_param.md
Name: spi_slave_rx_param

Overview:
Parametrised SPI slave receiver, the next-generation ADC/control SPI input for the oscillator FPGA. It runs fully synchronously on the system clock, with no logic clocked by the SPI clock. It oversamples and glitch-filters NSS and SCLK, supports all four CPOL/CPHA modes and configurable word width and bit order, and delivers words through a valid/ready handshake with overrun and framing-error reporting.

Parameters:
DATA_WIDTH, 16, bits per word (2..32)
FILTER_LEN, 2, consecutive clock samples needed to accept a level change on NSS/SCLK (1..15)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = first received bit lands in data_out[DATA_WIDTH-1], 0 = lands in data_out[0]

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
spi_nss  in  1  chip select, active low, asynchronous to clock
spi_clock_in  in  1  SPI SCLK, asynchronous
spi_data_in  in  1  SPI MOSI, asynchronous
data_out  out  DATA_WIDTH  last accepted word
data_valid  out  1  word available; held until data_ready
data_ready  in  1  consumer accepts word when data_valid & data_ready
overrun  out  1  1-cycle pulse: word completed while data_valid still high; that new word is discarded
frame_error  out  1  1-cycle pulse: NSS deasserted with partial word (1..DATA_WIDTH-1 bits)
busy  out  1  high while filtered NSS is low

Behaviour:
- Reset (async, active-high) clears every flop:
  - data_out=0, data_valid=0, overrun=0, frame_error=0, busy=0.
  - Internal filtered NSS=1, filtered SCLK=CPOL, bit counter=0, state=IDLE.
- Input conditioning:
  - All three inputs pass through 2-flop synchronisers.
  - NSS and SCLK each go through a filter. The filtered value changes only after the synchronised input has differed from it for FILTER_LEN consecutive clocks. The filter counter clears whenever input and filtered value agree.
  - MOSI is synchronised only.
- Sample edge:
  - Rising edge of filtered SCLK when CPOL==CPHA, falling edge otherwise.
  - Detected by comparing filtered SCLK with its 1-cycle delayed copy.
  - The synchronised MOSI value in that cycle is the captured bit.
- Timing constraint, not checked in hardware: each SCLK half-period ≥ FILTER_LEN+4 clocks.
- State machine:
  - IDLE:
    - Filtered NSS low -> SHIFT.
    - Bit counter=0, shift register cleared.
    - busy=1 from this transition onward.
  - SHIFT:
    - On each sample edge: shift in bit, counter+1.
    - At counter==DATA_WIDTH-1 with a sample edge: word completes and counter wraps to 0. State stays SHIFT, so multiple words per NSS frame are allowed.
    - Filtered NSS high -> IDLE and busy=0.
    - If counter≠0 at that moment, frame_error pulses for 1 cycle and the partial word is dropped.
    - If NSS rises in the same cycle as a sample edge, the edge is ignored.
- Word completion:
  - If data_valid=0, or data_valid & data_ready in the same cycle: data_out<=word and data_valid<=1 on the next clock.
  - Otherwise: overrun pulses for 1 cycle, data_out and data_valid are unchanged, and the word is lost.
- Handshake:
  - data_valid falls the cycle after data_valid & data_ready unless a new word loads in the same cycle, in which case it stays high.
  - data_out is stable while data_valid=1.
- Latency: from the SCLK sampling edge of the last bit at the pin to data_valid high is FILTER_LEN+3 clocks, +1 allowed for synchroniser phase.
- Edges while filtered NSS is high are ignored.
- Glitches shorter than FILTER_LEN clocks on NSS or SCLK have no effect.
- Reset mid-word: the partial word is discarded, with no frame_error and no data_valid.
- SCLK activity during IDLE→SHIFT entry: a sample edge in the same cycle NSS filters low is not captured. The master must respect a setup of ≥ FILTER_LEN+4 clocks from NSS low to the first SCLK edge.

Test Plan:
- Mode 0, DATA_WIDTH=16, MSB_FIRST=1: send 0xA5C3 with 20-clock half-periods and data_ready=1 -> data_out=0xA5C3, one data_valid pulse within FILTER_LEN+3..+4 clocks of the 16th rising edge, no errors.
- Repeat for modes 1, 2 and 3 and for MSB_FIRST=0: send 0x1234 -> data_out=0x1234 with bits in the correct order. In LSB-first mode the wire sequence is bit0 first.
- Glitch: 1-clock SCLK pulses and 1-clock NSS high pulses injected mid-word with FILTER_LEN=2 -> word 0xBEEF still received intact, no frame_error.
- NSS raised after 7 bits -> frame_error pulses once, data_valid stays 0. Next full frame carrying 0x00FF is received correctly.
- data_ready=0, two back-to-back words 0x1111 then 0x2222 in one NSS frame -> data_valid=1 with data_out=0x1111; overrun pulses once at the second completion. Raising data_ready clears data_valid and data_out stays 0x1111.
- Assert reset after 9 bits -> all outputs 0 immediately. After release, a fresh frame with 0x8001 is received correctly and frame_error is never asserted.
